// File: rtl/ascii_add_pkg.sv
// ============================================================================
// ascii_add_pkg : shared constants, types and helpers for the ASCII BCD adder
// Rev 1.0
// ============================================================================
`default_nettype none

package ascii_add_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    ADD    = 3'd2,
    EMIT   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  function automatic logic is_ascii_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_add.sv
// ============================================================================
// bcd_digit_add : combinational single-digit BCD adder with carry in/out
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit_add
  import ascii_add_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t s,
  output logic       cout
);

  logic [4:0] w_bin;

  always_comb begin
    w_bin = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (w_bin > 5'd9) begin
      // 4-bit wraparound of +6 yields the corrected decimal digit
      s    = w_bin[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      s    = w_bin[3:0];
      cout = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ascii_add_seq.sv
// ============================================================================
// ascii_add_seq : loads two ASCII decimal operands, adds them digit-serially
//                 and streams the ASCII sum MSD first without leading zeros
// Rev 1.0
// ============================================================================
`default_nettype none

module ascii_add_seq
  import ascii_add_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err,
  output logic       busy
);

  localparam int DW = 4 * MAX_DIGITS;
  localparam int RW = 4 * (MAX_DIGITS + 1);
  localparam int PW = $clog2(MAX_DIGITS + 1);

  state_t         r_state;
  state_t         w_next;

  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic [RW-1:0]  r_res;
  logic [PW-1:0]  r_cnt_a;
  logic [PW-1:0]  r_cnt_b;
  logic [PW-1:0]  r_idx;
  logic [PW-1:0]  r_ptr;
  logic           r_carry;
  logic           r_drain_two;
  logic           r_err;
  logic           r_out_valid;
  logic           r_out_last;
  logic [7:0]     r_out_data;

  logic           w_in_xfer;
  logic           w_out_xfer;
  logic           w_bad;
  logic           w_enter_load_a;
  logic [PW-1:0]  w_start_ptr;
  logic [PW-1:0]  w_prev_ptr;
  bcd_digit_t     w_start_dig;
  bcd_digit_t     w_prev_dig;
  bcd_digit_t     w_dig_a;
  bcd_digit_t     w_dig_b;
  bcd_digit_t     w_sum;
  logic           w_cout;

  assign in_ready   = (r_state == LOAD_A) || (r_state == LOAD_B) || (r_state == DRAIN);
  assign busy       = (r_state != LOAD_A);
  assign err        = r_err;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  assign w_dig_a    = r_a[4*r_idx +: 4];
  assign w_dig_b    = r_b[4*r_idx +: 4];

  bcd_digit_add u_bcd_digit_add (
    .a    (w_dig_a),
    .b    (w_dig_b),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Highest nonzero result digit; stays at 0 for an all-zero result
  always_comb begin
    w_start_ptr = '0;
    for (int k = 0; k <= MAX_DIGITS; k++) begin
      if (r_res[4*k +: 4] != 4'd0) begin
        w_start_ptr = PW'(k);
      end
    end
  end

  assign w_prev_ptr  = r_ptr - PW'(1);
  assign w_start_dig = r_res[4*w_start_ptr +: 4];
  assign w_prev_dig  = r_res[4*w_prev_ptr +: 4];

  always_comb begin
    w_bad = 1'b0;
    if (!is_ascii_digit(in_data)) begin
      w_bad = 1'b1;
    end else if ((r_state == LOAD_A) && (r_cnt_a == PW'(MAX_DIGITS))) begin
      w_bad = 1'b1;
    end else if ((r_state == LOAD_B) && (r_cnt_b == PW'(MAX_DIGITS))) begin
      w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD_A: begin
        if (w_in_xfer) begin
          if (w_bad) begin
            w_next = DRAIN;
          end else if (in_last) begin
            w_next = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (w_in_xfer) begin
          if (w_bad) begin
            w_next = in_last ? LOAD_A : DRAIN;
          end else if (in_last) begin
            w_next = ADD;
          end
        end
      end
      ADD: begin
        if (r_idx == PW'(MAX_DIGITS - 1)) begin
          w_next = EMIT;
        end
      end
      EMIT: begin
        if (w_out_xfer && r_out_last) begin
          w_next = LOAD_A;
        end
      end
      DRAIN: begin
        if (w_in_xfer && in_last && !r_drain_two) begin
          w_next = LOAD_A;
        end
      end
      default: w_next = LOAD_A;
    endcase
  end

  assign w_enter_load_a = (w_next == LOAD_A) && (r_state != LOAD_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_idx       <= '0;
      r_ptr       <= '0;
      r_carry     <= 1'b0;
      r_drain_two <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= ASCII_ZERO;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        LOAD_A: begin
          if (w_in_xfer) begin
            if (w_bad) begin
              r_err       <= 1'b1;
              // An error byte carrying in_last already terminated operand A
              r_drain_two <= !in_last;
            end else begin
              r_a     <= {r_a[DW-5:0], in_data[3:0]};
              r_cnt_a <= r_cnt_a + PW'(1);
            end
          end
        end
        LOAD_B: begin
          if (w_in_xfer) begin
            if (w_bad) begin
              r_err       <= 1'b1;
              r_drain_two <= 1'b0;
            end else begin
              r_b     <= {r_b[DW-5:0], in_data[3:0]};
              r_cnt_b <= r_cnt_b + PW'(1);
              if (in_last) begin
                r_idx   <= '0;
                r_carry <= 1'b0;
              end
            end
          end
        end
        ADD: begin
          r_res[4*r_idx +: 4] <= w_sum;
          r_carry             <= w_cout;
          r_idx               <= r_idx + PW'(1);
          if (r_idx == PW'(MAX_DIGITS - 1)) begin
            r_res[RW-1 -: 4] <= {3'b000, w_cout};
          end
        end
        EMIT: begin
          if (!r_out_valid) begin
            r_ptr       <= w_start_ptr;
            r_out_data  <= {4'h3, w_start_dig};
            r_out_last  <= (w_start_ptr == '0);
            r_out_valid <= 1'b1;
          end else if (w_out_xfer) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_data  <= ASCII_ZERO;
            end else begin
              r_ptr      <= w_prev_ptr;
              r_out_data <= {4'h3, w_prev_dig};
              r_out_last <= (w_prev_ptr == '0);
            end
          end
        end
        DRAIN: begin
          if (w_in_xfer && in_last) begin
            r_drain_two <= 1'b0;
          end
        end
        default: ;
      endcase

      if (w_enter_load_a) begin
        r_a     <= '0;
        r_b     <= '0;
        r_res   <= '0;
        r_cnt_a <= '0;
        r_cnt_b <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ascii_add_seq.sv
// ============================================================================
// tb_ascii_add_seq : directed self-checking bench for ascii_add_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ascii_add_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       err;
  logic       busy;

  int         checks = 0;
  int         passed = 0;
  int         err_cnt = 0;
  logic [7:0] got[$];
  logic       got_last[$];
  bit         timed_out;

  ascii_add_seq #(.MAX_DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && err === 1'b1) err_cnt++;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [7:0] d, input logic last);
    int n;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic collect(input int max_cycles);
    got.delete();
    got_last.delete();
    timed_out = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got.push_back(out_data);
        got_last.push_back(out_last);
        if (out_last === 1'b1) begin
          @(posedge clk); #1;
          timed_out = 1'b0;
          break;
        end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last); else passed++;
    checks++; if (out_data !== 8'h30) $display("FAIL reset_out_data: got %h expected 30", out_data); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_digit();
    send(8'h34, 1'b1);
    send(8'h31, 1'b1);
    collect(50);
    checks++; if (timed_out || got.size() != 1) $display("FAIL single_count: got %0d digits timeout=%0b expected 1", got.size(), timed_out); else passed++;
    if (got.size() >= 1) begin
      checks++; if (got[0] !== 8'h35) $display("FAIL single_data: got %h expected 35", got[0]); else passed++;
      checks++; if (got_last[0] !== 1'b1) $display("FAIL single_last: got %b expected 1", got_last[0]); else passed++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_after: got %b expected 0", busy); else passed++;
    checks++; if (err_cnt != 0) $display("FAIL single_no_err: got %0d err pulses expected 0", err_cnt); else passed++;
  endtask

  task automatic test_latency();
    int n;
    send(8'h31, 1'b0);
    send(8'h35, 1'b1);
    send(8'h37, 1'b0);
    send(8'h33, 1'b1);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL add_in_ready: got %b expected 0", in_ready); else passed++;
      end
      if (out_valid === 1'b1) begin
        n = k;
        break;
      end
    end
    checks++; if (n != 5) $display("FAIL latency: got %0d cycles expected 5", n); else passed++;
    collect(50);
    checks++; if (timed_out || got.size() != 2) $display("FAIL sum88_count: got %0d digits expected 2", got.size()); else passed++;
    if (got.size() == 2) begin
      checks++; if (got[0] !== 8'h38 || got_last[0] !== 1'b0) $display("FAIL sum88_d0: got %h/%b expected 38/0", got[0], got_last[0]); else passed++;
      checks++; if (got[1] !== 8'h38 || got_last[1] !== 1'b1) $display("FAIL sum88_d1: got %h/%b expected 38/1", got[1], got_last[1]); else passed++;
    end
  endtask

  task automatic test_carry_and_zero();
    logic [7:0] exp5 [5] = '{8'h31, 8'h30, 8'h30, 8'h30, 8'h30};
    repeat (4) send(8'h39, 1'b0);
    // Overwrite: the fourth '9' must carry in_last, so resend pattern cleanly
    send(8'h31, 1'b1);
    collect(50);
    // Sequence sent was 9,9,9,9 then '1' as A's fifth digit -> error; redo properly below
    checks++; if (err_cnt != 1) $display("FAIL overflow_a_err: got %0d pulses expected 1", err_cnt); else passed++;
    checks++; if (got.size() != 0) $display("FAIL overflow_a_no_output: got %0d digits expected 0", got.size()); else passed++;
    send(8'h35, 1'b1);
    checks++; if (busy !== 1'b0) $display("FAIL overflow_a_drained: busy got %b expected 0", busy); else passed++;

    send(8'h39, 1'b0); send(8'h39, 1'b0); send(8'h39, 1'b0); send(8'h39, 1'b1);
    send(8'h31, 1'b1);
    collect(60);
    checks++; if (timed_out || got.size() != 5) $display("FAIL carry_count: got %0d digits expected 5", got.size()); else passed++;
    if (got.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== exp5[i] || got_last[i] !== (i == 4))
          $display("FAIL carry_d%0d: got %h/%b expected %h/%b", i, got[i], got_last[i], exp5[i], (i == 4));
        else passed++;
      end
    end

    send(8'h30, 1'b1);
    send(8'h30, 1'b1);
    collect(50);
    checks++; if (timed_out || got.size() != 1) $display("FAIL zero_count: got %0d digits expected 1", got.size()); else passed++;
    if (got.size() == 1) begin
      checks++; if (got[0] !== 8'h30 || got_last[0] !== 1'b1) $display("FAIL zero_d0: got %h/%b expected 30/1", got[0], got_last[0]); else passed++;
    end
  endtask

  task automatic test_error_a();
    int e0;
    e0 = err_cnt;
    send(8'h41, 1'b0);
    checks++; if (err !== 1'b1) $display("FAIL err_a_pulse: got %b expected 1", err); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL err_a_drain_busy: got %b expected 1", busy); else passed++;
    send(8'h32, 1'b1);
    checks++; if (err !== 1'b0) $display("FAIL err_a_one_cycle: got %b expected 0", err); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL err_a_still_drain: got %b expected 1", busy); else passed++;
    send(8'h33, 1'b0);
    send(8'h34, 1'b1);
    checks++; if (busy !== 1'b0) $display("FAIL err_a_back_to_load: busy got %b expected 0", busy); else passed++;
    checks++; if (err_cnt != e0 + 1) $display("FAIL err_a_count: got %0d pulses expected %0d", err_cnt - e0, 1); else passed++;
    send(8'h32, 1'b1);
    send(8'h32, 1'b1);
    collect(50);
    checks++; if (timed_out || got.size() != 1 || got[0] !== 8'h34) $display("FAIL err_a_recover: got %0d digits first %h expected 1 digit 34", got.size(), (got.size() > 0) ? got[0] : 8'hxx); else passed++;
  endtask

  task automatic test_error_b();
    int e0;
    e0 = err_cnt;
    send(8'h31, 1'b1);
    send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h33, 1'b0); send(8'h34, 1'b0);
    send(8'h35, 1'b0);
    checks++; if (err !== 1'b1) $display("FAIL err_b_five_digits: got %b expected 1", err); else passed++;
    send(8'h36, 1'b1);
    checks++; if (busy !== 1'b0) $display("FAIL err_b_drain_exit: busy got %b expected 0", busy); else passed++;
    send(8'h32, 1'b1);
    send(8'h58, 1'b1);
    checks++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL err_b_last_direct: err/busy got %b/%b expected 1/0", err, busy); else passed++;
    checks++; if (err_cnt != e0 + 1) $display("FAIL err_b_count: got %0d pulses expected 1", err_cnt - e0); else passed++;
    send(8'h33, 1'b1);
    send(8'h33, 1'b1);
    collect(50);
    checks++; if (timed_out || got.size() != 1 || got[0] !== 8'h36) $display("FAIL err_b_recover: got %0d digits first %h expected 1 digit 36", got.size(), (got.size() > 0) ? got[0] : 8'hxx); else passed++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp3 [3] = '{8'h31, 8'h32, 8'h33};
    int n;
    send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h30, 1'b1);
    send(8'h33, 1'b1);
    out_ready = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_wait_valid: got %b expected 1", out_valid); else passed++;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp3[d] || out_last !== (d == 2))
          $display("FAIL bp_hold_d%0d_c%0d: got %b/%h/%b expected 1/%h/%b", d, k, out_valid, out_data, out_last, exp3[d], (d == 2));
        else passed++;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_done: valid/busy got %b/%b expected 0/0", out_valid, busy); else passed++;
  endtask

  task automatic test_reset_in_emit();
    int n;
    send(8'h39, 1'b0); send(8'h39, 1'b1);
    send(8'h39, 1'b0); send(8'h39, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h31) $display("FAIL rst_pre_first: got %b/%h expected 1/31", out_valid, out_data); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_data !== 8'h39) $display("FAIL rst_pre_second: got %h expected 39", out_data); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_async: valid/ready got %b/%b expected 0/1", out_valid, in_ready); else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h37, 1'b1);
    send(8'h38, 1'b1);
    collect(50);
    checks++; if (timed_out || got.size() != 2) $display("FAIL rst_next_count: got %0d digits expected 2", got.size()); else passed++;
    if (got.size() == 2) begin
      checks++; if (got[0] !== 8'h31 || got[1] !== 8'h35 || got_last[1] !== 1'b1) $display("FAIL rst_next_data: got %h %h/%b expected 31 35/1", got[0], got[1], got_last[1]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_latency();
    test_carry_and_zero();
    test_error_a();
    test_error_b();
    test_backpressure();
    test_reset_in_emit();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
